seq_divider: RTL and testbench

Multicycle unsigned integer divider: the inverse-direction companion to the combinational add/subtract datapath. Accepts an N-bit dividend and divisor on a start pulse and computes quotient and remainder by non-restoring division, one quotient bit per clock, reusing a single (N+1)-bit add/subtract unit. It sits beside the ALU as the long-latency divide unit, driven by a start/done handshake from the controller.

---
 rtl/seq_divider_pkg.sv | 35 +++
 rtl/seq_divider_if.sv | 53 +++++
 rtl/seq_divider_addsub.sv | 38 +++
 rtl/seq_divider.sv | 167 ++++++++++++++++
 tb/tb_seq_divider.sv | 287 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/seq_divider_pkg.sv
// ---------------------------------------------------------------------------
// seq_divider_pkg
//
// Shared definitions for the multicycle divide unit.
//   DIV_W          default operand / quotient / remainder width
//   divState_t     controller states of the divider
//   countWidth()   width of the iteration counter for a given operand width
// ---------------------------------------------------------------------------
package seq_divider_pkg;

  localparam int DIV_W = 32;

  // IDLE: waiting for a request
  // RUN : one quotient bit per clock
  // FIX : final remainder correction and result publish
  // DONE: one-cycle completion pulse, also accepts the next request
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } divState_t;

  // The counter walks from n-1 down to 0, so $clog2(n) bits are enough.
  // The max() guard keeps a one-bit counter legal for the smallest width.
  function automatic int countWidth(input int n);
    int w;
    w = $clog2(n);
    if (w < 1) begin
      w = 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/seq_divider_if.sv
// ---------------------------------------------------------------------------
// seq_divider_if
//
// Start/done handshake between the controller and the divide unit.
//   start        request pulse, only honoured when the divider is not busy
//   dividend     unsigned dividend, sampled with start
//   divisor      unsigned divisor, sampled with start
//   busy         divider is iterating or correcting
//   done         one-cycle pulse, results are valid
//   quotient     held result
//   remainder    held result
//   div_by_zero  held flag, set when the accepted divisor was zero
//
// master: the controller side, slave: the divider side.
// ---------------------------------------------------------------------------
interface seq_divider_if
  import seq_divider_pkg::*;
#(
  parameter int N = DIV_W
);

  logic         start;
  logic [N-1:0] dividend;
  logic [N-1:0] divisor;
  logic         busy;
  logic         done;
  logic [N-1:0] quotient;
  logic [N-1:0] remainder;
  logic         div_by_zero;

  modport master (
    output start,
    output dividend,
    output divisor,
    input  busy,
    input  done,
    input  quotient,
    input  remainder,
    input  div_by_zero
  );

  modport slave (
    input  start,
    input  dividend,
    input  divisor,
    output busy,
    output done,
    output quotient,
    output remainder,
    output div_by_zero
  );

endinterface

// File: rtl/seq_divider_addsub.sv
// ---------------------------------------------------------------------------
// seq_divider_addsub
//
// Ripple-carry add/subtract datapath, the same structure as the ALU adder.
//   i_a    first operand
//   i_b    second operand
//   i_sub  1: o_sum = i_a - i_b, 0: o_sum = i_a + i_b
//   o_sum  W-bit result, carry-out is not produced
// ---------------------------------------------------------------------------
module seq_divider_addsub
  import seq_divider_pkg::*;
#(
  parameter int W = DIV_W + 1
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  input  logic         i_sub,
  output logic [W-1:0] o_sum
);

  logic [W-1:0] w_bInv;

  // Subtraction is a + ~b + 1: invert b and feed the select in as carry-in.
  assign w_bInv = i_b ^ {W{i_sub}};

  // Bit-serial ripple chain. The carry out of the top bit is simply dropped,
  // the caller works modulo 2^W.
  always_comb begin : rippleChain
    logic w_carry;
    o_sum   = '0;
    w_carry = i_sub;
    for (int i = 0; i < W; i++) begin
      o_sum[i] = i_a[i] ^ w_bInv[i] ^ w_carry;
      w_carry  = (i_a[i] & w_bInv[i]) | (w_carry & (i_a[i] ^ w_bInv[i]));
    end
  end

endmodule

// File: rtl/seq_divider.sv
// ---------------------------------------------------------------------------
// seq_divider
//
// Multicycle unsigned divider using non-restoring division, one quotient bit
// per clock through a single (N+1)-bit add/subtract unit.
//   i_clk      system clock, rising edge
//   i_rst      synchronous active-high reset, highest priority
//   io_divBus  start/dividend/divisor in, busy/done/quotient/remainder/
//              div_by_zero out (slave side of seq_divider_if)
//
// A request takes N+2 cycles from the accepting edge to the done pulse
// (N RUN iterations, one FIX cycle, then DONE). A zero divisor completes in
// one cycle with an all-ones quotient and the dividend as remainder.
// ---------------------------------------------------------------------------
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int N = DIV_W
) (
  input  logic          i_clk,
  input  logic          i_rst,
  seq_divider_if.slave  io_divBus
);

  localparam int CW = countWidth(N);

  divState_t    r_state;
  divState_t    w_nextState;

  logic [N:0]   r_partialRem;
  logic [N-1:0] r_quoShift;
  logic [N-1:0] r_divisorHold;
  logic [CW-1:0] r_count;
  logic [N-1:0] r_quotient;
  logic [N-1:0] r_remainder;
  logic         r_divByZero;

  logic         w_accept;
  logic         w_zeroDivisor;
  logic [N:0]   w_addA;
  logic [N:0]   w_addB;
  logic         w_addSub;
  logic [N:0]   w_addSum;

  // A new request is only taken when nothing is in flight; starts that
  // arrive while busy are dropped rather than queued.
  always_comb begin
    w_accept      = 1'b0;
    w_zeroDivisor = (io_divBus.divisor == '0);
    if ((r_state == IDLE) || (r_state == DONE)) begin
      w_accept = io_divBus.start;
    end
  end

  // Next-state logic. DONE behaves like IDLE for accepting a request so a
  // controller can chain divisions without an idle cycle in between.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE, DONE: begin
        if (w_accept) begin
          w_nextState = w_zeroDivisor ? DONE : RUN;
        end else begin
          w_nextState = IDLE;
        end
      end
      RUN: begin
        if (r_count == '0) begin
          w_nextState = FIX;
        end
      end
      FIX: begin
        w_nextState = DONE;
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  // Adder operand steering. In RUN the adder sees the left-shifted partial
  // remainder (next dividend bit shifted in) and subtracts while the old
  // remainder is non-negative, adds back while it is negative. In FIX it
  // only ever adds, to pull a negative remainder back into range.
  always_comb begin
    w_addA   = r_partialRem;
    w_addSub = 1'b0;
    if (r_state == RUN) begin
      w_addA   = {r_partialRem[N-1:0], r_quoShift[N-1]};
      w_addSub = ~r_partialRem[N];
    end
  end

  assign w_addB = {1'b0, r_divisorHold};

  seq_divider_addsub #(
    .W (N + 1)
  ) u_addsub (
    .i_a   (w_addA),
    .i_b   (w_addB),
    .i_sub (w_addSub),
    .o_sum (w_addSum)
  );

  // All divider state. The published results only move on a zero-divisor
  // acceptance or when FIX hands over to DONE, so they stay stable for the
  // whole time the unit is busy with the next request.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state       <= IDLE;
      r_partialRem  <= '0;
      r_quoShift    <= '0;
      r_divisorHold <= '0;
      r_count       <= '0;
      r_quotient    <= '0;
      r_remainder   <= '0;
      r_divByZero   <= 1'b0;
    end else begin
      r_state <= w_nextState;
      case (r_state)
        IDLE, DONE: begin
          if (w_accept) begin
            if (w_zeroDivisor) begin
              r_quotient  <= '1;
              r_remainder <= io_divBus.dividend;
              r_divByZero <= 1'b1;
            end else begin
              r_divisorHold <= io_divBus.divisor;
              r_quoShift    <= io_divBus.dividend;
              r_partialRem  <= '0;
              r_count       <= CW'(N - 1);
            end
          end
        end
        RUN: begin
          // The dividend bits leave the top of the quotient register as the
          // quotient bits enter at the bottom; the new bit is 1 when the
          // updated partial remainder is non-negative.
          r_partialRem <= w_addSum;
          r_quoShift   <= {r_quoShift[N-2:0], ~w_addSum[N]};
          if (r_count != '0) begin
            r_count <= r_count - CW'(1);
          end
        end
        FIX: begin
          if (r_partialRem[N]) begin
            r_partialRem <= w_addSum;
            r_remainder  <= w_addSum[N-1:0];
          end else begin
            r_remainder  <= r_partialRem[N-1:0];
          end
          r_quotient  <= r_quoShift;
          r_divByZero <= 1'b0;
        end
        default: begin
        end
      endcase
    end
  end

  assign io_divBus.busy        = (r_state == RUN) || (r_state == FIX);
  assign io_divBus.done        = (r_state == DONE);
  assign io_divBus.quotient    = r_quotient;
  assign io_divBus.remainder   = r_remainder;
  assign io_divBus.div_by_zero = r_divByZero;

endmodule

// File: tb/tb_seq_divider.sv
// ---------------------------------------------------------------------------
// tb_seq_divider
//
// Bench for seq_divider. A reference model tracks what the outputs must be
// each cycle from the handshake rules and plain integer division; a compare
// process checks every cycle, and directed cases pin literal answers.
// ---------------------------------------------------------------------------
module tb_seq_divider;
  import seq_divider_pkg::*;

  localparam int N = DIV_W;

  logic clk;
  logic rst;

  int nVectors;
  int nMiscompares;

  seq_divider_if #(.N(N)) divBus ();

  seq_divider #(
    .N (N)
  ) dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .io_divBus (divBus)
  );

  // Free-running clock, 10 time units per period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model state: phase 0 idle, 1 busy, 2 done.
  bit           modelOn;
  int           mPhase;
  int           mLeft;
  logic [N-1:0] pendQ;
  logic [N-1:0] pendR;
  logic [N-1:0] expQ;
  logic [N-1:0] expR;
  logic         expZ;

  task automatic checkOutput(input string name, input logic [N-1:0] actual,
                             input logic [N-1:0] expected);
    nVectors++;
    if (actual !== expected) begin
      nMiscompares++;
      $display("[TB] FAIL %s: actual=%h required=%h", name, actual, expected);
    end
  endtask

  // Drive a one-cycle start; call just after a falling edge.
  task automatic applyStimulus(input logic [N-1:0] dvd, input logic [N-1:0] dvs);
    divBus.start    = 1'b1;
    divBus.dividend = dvd;
    divBus.divisor  = dvs;
    @(posedge clk);
    #1;
    divBus.start = 1'b0;
  endtask

  // Count falling edges after the accepting edge until done shows up.
  task automatic waitForDone(output int cycles, output int busyCycles);
    cycles     = 0;
    busyCycles = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      cycles++;
      if (divBus.busy) busyCycles++;
      if (divBus.done) return;
    end
    nVectors++;
    nMiscompares++;
    $display("[TB] FAIL done_timeout: actual=no done required=done within 200 cycles");
  endtask

  // Model: a request is busy for N+1 cycles, then done for one cycle, at
  // which point the results become quotient/remainder of plain division.
  always @(posedge clk) begin
    if (rst) begin
      modelOn = 1'b1;
      mPhase  = 0;
      mLeft   = 0;
      expQ    = '0;
      expR    = '0;
      expZ    = 1'b0;
    end else if (mPhase != 1) begin
      if (divBus.start) begin
        if (divBus.divisor == '0) begin
          expQ   = '1;
          expR   = divBus.dividend;
          expZ   = 1'b1;
          mPhase = 2;
        end else begin
          pendQ  = divBus.dividend / divBus.divisor;
          pendR  = divBus.dividend % divBus.divisor;
          mLeft  = N + 1;
          mPhase = 1;
        end
      end else begin
        mPhase = 0;
      end
    end else begin
      mLeft--;
      if (mLeft == 0) begin
        mPhase = 2;
        expQ   = pendQ;
        expR   = pendR;
        expZ   = 1'b0;
      end
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (modelOn) begin
      checkOutput("cyc_busy", {{(N-1){1'b0}}, divBus.busy}, {{(N-1){1'b0}}, (mPhase == 1)});
      checkOutput("cyc_done", {{(N-1){1'b0}}, divBus.done}, {{(N-1){1'b0}}, (mPhase == 2)});
      checkOutput("cyc_quotient", divBus.quotient, expQ);
      checkOutput("cyc_remainder", divBus.remainder, expR);
      checkOutput("cyc_div_by_zero", {{(N-1){1'b0}}, divBus.div_by_zero}, {{(N-1){1'b0}}, expZ});
    end
  end

  logic [N-1:0] edgeDvd [3];
  logic [N-1:0] edgeDvs [3];
  logic [N-1:0] edgeQ   [3];
  logic [N-1:0] edgeR   [3];

  // Directed cases followed by the randomized run.
  initial begin
    int           lat;
    int           bc;
    int           extra;
    int           gap;
    bit           finished;
    bit           ok;
    logic [N-1:0] dvd;
    logic [N-1:0] dvs;

    nVectors        = 0;
    nMiscompares    = 0;
    modelOn         = 1'b0;
    rst             = 1'b1;
    divBus.start    = 1'b0;
    divBus.dividend = '0;
    divBus.divisor  = '0;

    edgeDvd = '{32'hFFFF_FFFF, 32'd3,  32'h8000_0000};
    edgeDvs = '{32'd1,         32'd10, 32'hFFFF_FFFF};
    edgeQ   = '{32'hFFFF_FFFF, 32'd0,  32'd0};
    edgeR   = '{32'd0,         32'd3,  32'h8000_0000};

    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_busy", {{(N-1){1'b0}}, divBus.busy}, '0);
    checkOutput("reset_done", {{(N-1){1'b0}}, divBus.done}, '0);
    checkOutput("reset_quotient", divBus.quotient, '0);
    checkOutput("reset_remainder", divBus.remainder, '0);
    rst = 1'b0;

    $display("[TB] basic 100/7");
    @(negedge clk);
    applyStimulus(32'd100, 32'd7);
    waitForDone(lat, bc);
    checkOutput("basic_latency", lat, 34);
    checkOutput("basic_busy_cycles", bc, 33);
    checkOutput("basic_quotient", divBus.quotient, 32'd14);
    checkOutput("basic_remainder", divBus.remainder, 32'd2);

    $display("[TB] edge operands");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      applyStimulus(edgeDvd[i], edgeDvs[i]);
      waitForDone(lat, bc);
      checkOutput("edge_quotient", divBus.quotient, edgeQ[i]);
      checkOutput("edge_remainder", divBus.remainder, edgeR[i]);
    end

    $display("[TB] divide by zero");
    @(negedge clk);
    applyStimulus(32'd5, 32'd0);
    waitForDone(lat, bc);
    checkOutput("dbz_latency", lat, 1);
    checkOutput("dbz_busy_cycles", bc, 0);
    checkOutput("dbz_flag", {{(N-1){1'b0}}, divBus.div_by_zero}, 1);
    checkOutput("dbz_quotient", divBus.quotient, 32'hFFFF_FFFF);
    checkOutput("dbz_remainder", divBus.remainder, 32'd5);

    $display("[TB] start while busy");
    @(negedge clk);
    applyStimulus(32'd50000, 32'd123);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      applyStimulus($urandom, $urandom);
    end
    waitForDone(lat, bc);
    checkOutput("reject_quotient", divBus.quotient, 32'd406);
    checkOutput("reject_remainder", divBus.remainder, 32'd62);
    extra = 0;
    repeat (40) begin
      @(negedge clk);
      if (divBus.done) extra++;
    end
    checkOutput("reject_single_done", extra, 0);

    $display("[TB] back-to-back");
    @(negedge clk);
    applyStimulus(32'd100, 32'd7);
    waitForDone(lat, bc);
    applyStimulus(32'd1000, 32'd33);
    waitForDone(lat, bc);
    checkOutput("b2b_latency", lat, 34);
    checkOutput("b2b_quotient", divBus.quotient, 32'd30);
    checkOutput("b2b_remainder", divBus.remainder, 32'd10);

    $display("[TB] reset mid-run");
    @(negedge clk);
    applyStimulus(32'd9999, 32'd3);
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("rst_busy", {{(N-1){1'b0}}, divBus.busy}, '0);
    checkOutput("rst_quotient", divBus.quotient, '0);
    checkOutput("rst_remainder", divBus.remainder, '0);
    extra = 0;
    repeat (40) begin
      @(negedge clk);
      if (divBus.done) extra++;
    end
    checkOutput("rst_no_done", extra, 0);
    applyStimulus(32'd9, 32'd4);
    waitForDone(lat, bc);
    checkOutput("rst_after_quotient", divBus.quotient, 32'd2);
    checkOutput("rst_after_remainder", divBus.remainder, 32'd1);

    $display("[TB] random operands");
    for (int op = 0; op < 1500; op++) begin
      dvd = $urandom;
      case ($urandom % 4)
        0: dvs = $urandom;
        1: dvs = $urandom >> $urandom_range(0, 31);
        2: dvs = $urandom_range(1, 16);
        default: dvs = dvd >> $urandom_range(0, 4);
      endcase
      if (($urandom % 16) == 0) dvs = '0;
      gap = $urandom % 3;
      repeat (gap) @(negedge clk);
      applyStimulus(dvd, dvs);
      finished = 1'b0;
      for (int k = 0; k < 200 && !finished; k++) begin
        @(negedge clk);
        if (divBus.done) begin
          divBus.start = 1'b0;
          finished     = 1'b1;
        end else if (divBus.busy && (($urandom % 8) == 0)) begin
          divBus.start    = 1'b1;
          divBus.dividend = $urandom;
          divBus.divisor  = $urandom;
        end else begin
          divBus.start = 1'b0;
        end
      end
      if (!finished) begin
        nVectors++;
        nMiscompares++;
        $display("[TB] FAIL rand_timeout: actual=no done required=done within 200 cycles");
      end else if (dvs == '0) begin
        checkOutput("rand_dbz_flag", {{(N-1){1'b0}}, divBus.div_by_zero}, 1);
      end else begin
        ok = ((64'(divBus.quotient) * 64'(dvs) + 64'(divBus.remainder)) == 64'(dvd))
             && (divBus.remainder < dvs);
        checkOutput("rand_invariant", {{(N-1){1'b0}}, ok}, 1);
      end
    end

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $finish;
  end

endmodule
